// File: rtl/spi_memory_bridge.sv
// spi_memory_bridge: orders SPI client writes/reads onto a valid/ready memory port with a write FIFO
module spi_memory_bridge #(
   parameter int MESSAGE_BIT_WIDTH       = 32,
   parameter int CODE_BIT_WIDTH          = 4,
   parameter int START_ADDRESS_BIT_WIDTH = 16,
   parameter int FIFO_DEPTH              = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               write_new,
   input  logic                               read_sync,
   input  logic [CODE_BIT_WIDTH-1:0]          code,
   input  logic [START_ADDRESS_BIT_WIDTH-1:0] current_address,
   input  logic [MESSAGE_BIT_WIDTH-1:0]       MOSI_data,
   output logic [MESSAGE_BIT_WIDTH-1:0]       MISO_data,
   output logic                               mem_req_valid,
   input  logic                               mem_req_ready,
   output logic                               mem_req_write,
   output logic [CODE_BIT_WIDTH-1:0]          mem_req_code,
   output logic [START_ADDRESS_BIT_WIDTH-1:0] mem_req_address,
   output logic [MESSAGE_BIT_WIDTH-1:0]       mem_req_wdata,
   input  logic                               mem_rsp_valid,
   input  logic [MESSAGE_BIT_WIDTH-1:0]       mem_rsp_rdata,
   output logic                               busy,
   output logic                               overflow,
   output logic                               read_overrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = CODE_BIT_WIDTH + START_ADDRESS_BIT_WIDTH + MESSAGE_BIT_WIDTH;
   typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_WAIT} state_t;
   state_t                             state_q, state_d;
   logic [EW-1:0]                      fifo_q [FIFO_DEPTH];
   logic [AW-1:0]                      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]                      count_q, count_d;
   logic [CODE_BIT_WIDTH-1:0]          rd_code_q;
   logic [START_ADDRESS_BIT_WIDTH-1:0] rd_addr_q;
   logic                               pending_q, overflow_q, overrun_q;
   logic [MESSAGE_BIT_WIDTH-1:0]       miso_q;
   logic                               push_req, push, pop, rsp_take;
   // code 0 targets the config memory, which consumes those writes directly
   assign push_req = write_new && (code != '0);
   assign pop      = (state_q == WRITE) && mem_req_ready;
   assign push     = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);
   assign rsp_take = (state_q == READ_WAIT) && mem_rsp_valid;
   assign count_d  = count_q + CW'(push) - CW'(pop);
   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   // FIFO storage needs no reset; the pointers and count define validity
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {code, current_address, MOSI_data};
   end
   // FIFO pointers, read slot, captured response and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_code_q  <= '0;
         rd_addr_q  <= '0;
         pending_q  <= 1'b0;
         miso_q     <= '0;
         overflow_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         if (push_req && !push) overflow_q <= 1'b1;
         if (rsp_take) miso_q <= mem_rsp_rdata;
         if (read_sync && pending_q) overrun_q <= 1'b1;
         if (read_sync && !pending_q) begin
            rd_code_q <= code;
            rd_addr_q <= current_address;
            pending_q <= 1'b1;
         end else if (rsp_take) pending_q <= 1'b0;
      end
   end
   // next state: drain writes first so a read never overtakes an earlier write
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = (count_q != '0) ? WRITE : pending_q ? READ_REQ : IDLE;
         WRITE:     if (pop) state_d = (count_d != '0) ? WRITE : pending_q ? READ_REQ : IDLE;
         READ_REQ:  if (mem_req_ready) state_d = READ_WAIT;
         READ_WAIT: if (mem_rsp_valid) state_d = (count_q != '0) ? WRITE : IDLE;
         default:   state_d = IDLE;
      endcase
   end
   // request outputs come straight from state and stable registers, so they hold while stalled
   always_comb begin
      mem_req_valid = (state_q == WRITE) || (state_q == READ_REQ);
      mem_req_write = (state_q == WRITE);
      {mem_req_code, mem_req_address, mem_req_wdata} =
         (state_q == WRITE)    ? fifo_q[rd_ptr_q] :
         (state_q == READ_REQ) ? {rd_code_q, rd_addr_q, {MESSAGE_BIT_WIDTH{1'b0}}} : '0;
      busy          = (state_q != IDLE) || (count_q != '0) || pending_q;
      MISO_data     = miso_q;
      overflow      = overflow_q;
      read_overrun  = overrun_q;
   end
endmodule

// File: tb/tb_spi_memory_bridge.sv
// tb_spi_memory_bridge: queue-based reference model plus directed checks for spi_memory_bridge
module tb_spi_memory_bridge;
   localparam int M = 32;
   localparam int C = 4;
   localparam int A = 16;
   logic clk = 1'b0, rst = 1'b1, write_new = 1'b0, read_sync = 1'b0;
   logic [C-1:0] code = '0;
   logic [A-1:0] current_address = '0;
   logic [M-1:0] MOSI_data = '0, MISO_data, mem_req_wdata, mem_rsp_rdata = '0;
   logic mem_req_valid, mem_req_ready = 1'b0, mem_req_write, mem_rsp_valid = 1'b0;
   logic [C-1:0] mem_req_code;
   logic [A-1:0] mem_req_address;
   logic busy, overflow, read_overrun;
   int tests = 0, fails = 0;

   spi_memory_bridge dut (
      .clk(clk), .rst(rst), .write_new(write_new), .read_sync(read_sync), .code(code),
      .current_address(current_address), .MOSI_data(MOSI_data), .MISO_data(MISO_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
      .mem_req_code(mem_req_code), .mem_req_address(mem_req_address), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy),
      .overflow(overflow), .read_overrun(read_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // reference model: queue of accepted writes, one read slot, sticky flags
   logic [C+A+M-1:0] wq[$];
   bit pend, issued, ovf, ovr;
   logic [C-1:0] rc;
   logic [A-1:0] ra;
   logic [M-1:0] miso;
   bit hs_w[$];

   always @(posedge clk) begin
      bit pb, ib;
      pb = pend;
      ib = issued;
      if (rst) begin
         wq.delete(); pend = 0; issued = 0; ovf = 0; ovr = 0; miso = '0;
      end else begin
         if (ib && mem_rsp_valid) begin
            miso = mem_rsp_rdata; pend = 0; issued = 0;
         end
         if (mem_req_valid && mem_req_ready) begin
            hs_w.push_back(mem_req_write);
            if (mem_req_write) begin
               chk("wr_has_entry", wq.size() != 0, 1);
               if (wq.size() != 0) begin
                  chk("wr_req", {mem_req_code, mem_req_address, mem_req_wdata}, wq[0]);
                  void'(wq.pop_front());
               end
            end else begin
               chk("rd_order", {pb && !ib, wq.size() == 0}, 2'b11);
               chk("rd_req", {mem_req_code, mem_req_address}, {rc, ra});
               issued = 1;
            end
         end
         if (write_new && code != 0) begin
            if (wq.size() < 4) wq.push_back({code, current_address, MOSI_data});
            else ovf = 1;
         end
         if (read_sync) begin
            if (pb) ovr = 1;
            else begin
               pend = 1; rc = code; ra = current_address;
            end
         end
      end
   end

   logic [53:0] prev;
   bit st_prev = 0;
   always @(negedge clk) begin
      chk("overflow", overflow, ovf);
      chk("read_overrun", read_overrun, ovr);
      chk("miso", MISO_data, miso);
      chk("busy", busy, (wq.size() != 0) || pend);
      if (!mem_req_valid) chk("idle_zero", {mem_req_write, mem_req_code, mem_req_address, mem_req_wdata}, 0);
      if (st_prev) chk("stall_stable", {mem_req_valid, mem_req_write, mem_req_code, mem_req_address, mem_req_wdata}, prev);
      prev = {mem_req_valid, mem_req_write, mem_req_code, mem_req_address, mem_req_wdata};
      st_prev = mem_req_valid && !mem_req_ready && !rst;
   end

   task automatic cyc;
      @(posedge clk); #1;
   endtask
   task automatic wr(input logic [C-1:0] c, input logic [A-1:0] a, input logic [M-1:0] d);
      code = c; current_address = a; MOSI_data = d; write_new = 1; cyc; write_new = 0;
   endtask
   task automatic rd(input logic [C-1:0] c, input logic [A-1:0] a);
      code = c; current_address = a; read_sync = 1; cyc; read_sync = 0;
   endtask
   task automatic rsp(input logic [M-1:0] d);
      mem_rsp_rdata = d; mem_rsp_valid = 1; cyc; mem_rsp_valid = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      cyc; cyc; rst = 0;
      @(negedge clk);
      chk("rst_valid", mem_req_valid, 0);
      chk("rst_miso", MISO_data, 0);
      chk("rst_busy", busy, 0);
      mem_req_ready = 1;
      wr(3, 16'h0010, 32'hDEADBEEF);
      @(negedge clk); chk("t1_not_early", mem_req_valid, 0);
      cyc; @(negedge clk);
      chk("t1_valid", mem_req_valid, 1);
      chk("t1_write", mem_req_write, 1);
      chk("t1_code", mem_req_code, 3);
      chk("t1_addr", mem_req_address, 16'h0010);
      chk("t1_data", mem_req_wdata, 32'hDEADBEEF);
      cyc; @(negedge clk); chk("t1_busy_low", busy, 0);
      mem_req_ready = 0;
      for (int i = 0; i < 5; i++) wr(5, 16'h0100 + 16'(i), 32'hA0 + 32'(i));
      @(negedge clk);
      chk("t2_overflow", overflow, 1);
      chk("t2_stalled_head", mem_req_wdata, 32'hA0);
      cyc; mem_req_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_b2b_valid", mem_req_valid, 1);
         chk("t2_b2b_data", mem_req_wdata, 32'hA0 + 32'(i));
         cyc;
      end
      @(negedge clk); chk("t2_drained", mem_req_valid, 0);
      rd(5, 16'h0042);
      cyc; @(negedge clk);
      chk("t3_rd_valid", mem_req_valid, 1);
      chk("t3_rd_write", mem_req_write, 0);
      chk("t3_rd_addr", mem_req_address, 16'h0042);
      cyc; rsp(32'h12345678);
      @(negedge clk);
      chk("t3_miso", MISO_data, 32'h12345678);
      chk("t3_busy_low", busy, 0);
      n0 = hs_w.size();
      wr(2, 16'h0020, 32'h1); wr(2, 16'h0021, 32'h2); rd(6, 16'h0030);
      repeat (6) cyc;
      rsp(32'h0BADF00D);
      @(negedge clk);
      chk("t4_hs_count", hs_w.size(), n0 + 3);
      if (hs_w.size() >= n0 + 3) chk("t4_order", {hs_w[n0], hs_w[n0+1], hs_w[n0+2]}, 3'b110);
      chk("t4_miso", MISO_data, 32'h0BADF00D);
      rst = 1; cyc; rst = 0;
      n0 = hs_w.size();
      wr(0, 16'h0005, 32'hFFFF);
      repeat (3) cyc;
      @(negedge clk);
      chk("t5_code0_no_req", hs_w.size(), n0);
      chk("t5_code0_no_ovf", overflow, 0);
      mem_req_ready = 0;
      rd(7, 16'h0077); rd(7, 16'h0099);
      @(negedge clk);
      chk("t5_overrun", read_overrun, 1);
      chk("t5_first_addr", mem_req_address, 16'h0077);
      cyc; mem_req_ready = 1; cyc;
      rsp(32'h55AA55AA);
      @(negedge clk); chk("t5_miso", MISO_data, 32'h55AA55AA);
      rd(7, 16'h0011);
      repeat (3) cyc;
      rst = 1; cyc; rst = 0;
      @(negedge clk);
      chk("t6_rst_miso", MISO_data, 0);
      chk("t6_rst_valid", mem_req_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_overrun", read_overrun, 0);
      rsp(32'hCAFE);
      @(negedge clk); chk("t6_late_rsp_ignored", MISO_data, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_memory_bridge.md
# spi_memory_bridge

Clock-domain-side consumer of the SPI client's data path. Takes the synchronized `write_new` / `read_sync` pulses plus the client's `code`, `current_address` and `MOSI_data`, and issues them as ordered requests on a valid/ready memory port. Read responses are captured into `MISO_data` for the client to shift out. Write requests are buffered in a small FIFO so bursts of SPI writes survive memory back-pressure.

## Interface

Parameters:
- `MESSAGE_BIT_WIDTH`, 32: data word width; must match the SPI client.
- `CODE_BIT_WIDTH`, 4: target/code field width.
- `START_ADDRESS_BIT_WIDTH`, 16: address width.
- `FIFO_DEPTH`, 4: write-buffer entries; power of two, ≥2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: system clock.
  - `rst` input 1: synchronous reset, active-high.
- SPI client side:
  - `write_new` input 1: one-cycle pulse; a write word is stable on `code`/`current_address`/`MOSI_data`.
  - `read_sync` input 1: one-cycle pulse; read address is stable on `code`/`current_address`.
  - `code` input `CODE_BIT_WIDTH`: target code.
  - `current_address` input `START_ADDRESS_BIT_WIDTH`: word address.
  - `MOSI_data` input `MESSAGE_BIT_WIDTH`: write data.
  - `MISO_data` output `MESSAGE_BIT_WIDTH`: last read response, registered.
- Memory side:
  - `mem_req_valid` output 1: request valid.
  - `mem_req_ready` input 1: request accepted when high together with `mem_req_valid`.
  - `mem_req_write` output 1: 1 = write, 0 = read.
  - `mem_req_code` output `CODE_BIT_WIDTH`: request code.
  - `mem_req_address` output `START_ADDRESS_BIT_WIDTH`: request address.
  - `mem_req_wdata` output `MESSAGE_BIT_WIDTH`: write data.
  - `mem_rsp_valid` input 1: read data valid.
  - `mem_rsp_rdata` input `MESSAGE_BIT_WIDTH`: read data.
- Status:
  - `busy` output 1: high when the FSM is not in IDLE, the FIFO is non-empty, or a read is pending.
  - `overflow` output 1: sticky; a write was dropped because the FIFO was full.
  - `read_overrun` output 1: sticky; `read_sync` arrived while a read was pending.

## Operation

- Sampling:
  - On `write_new`, sample `{code, current_address, MOSI_data}`.
  - On `read_sync`, sample `{code, current_address}` into the read slot and set `read_pending`.
- Writes with `code == 0` are discarded. The config memory consumes these directly. They never set `overflow`.
- FIFO push:
  - Accepted when count < `FIFO_DEPTH`, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and `overflow` is set.
- `read_sync` while `read_pending` is already set: ignore the new read, keep the old address, set `read_overrun`.
- Ordering: a read is issued only after the FIFO is empty. Writes accepted before the read complete first.
- FSM states:
  - IDLE:
    - FIFO non-empty → WRITE.
    - Else, `read_pending` → READ_REQ.
  - WRITE:
    - `mem_req_valid`=1, `mem_req_write`=1, FIFO head on the request outputs.
    - On handshake, pop. If entries remain, stay in WRITE and present the next head in the next cycle (back-to-back).
    - Otherwise go to READ_REQ if `read_pending`, else IDLE.
  - READ_REQ: `mem_req_valid`=1, `mem_req_write`=0, read slot on the request outputs. On handshake → READ_WAIT.
  - READ_WAIT:
    - `mem_req_valid`=0.
    - On `mem_rsp_valid`: `MISO_data` ← `mem_rsp_rdata`, clear `read_pending`.
    - Then → WRITE if the FIFO is non-empty, else IDLE.
- Response filtering: `mem_rsp_valid` outside READ_WAIT is ignored.
- Request stability: while `mem_req_valid` && !`mem_req_ready`, all `mem_req_*` outputs hold stable.
- Idle request outputs: when `mem_req_valid`=0, `mem_req_write`/`code`/`address`/`wdata` are driven to 0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- Reset:
  - Resets all state: `MISO_data`=0, `mem_req_*`=0, `busy`=0, `overflow`=0, `read_overrun`=0, FIFO empty, `read_pending`=0, FSM=IDLE.
  - Reset mid-transaction abandons any outstanding read. A response arriving after reset is ignored.
  - `overflow` and `read_overrun` clear only on `rst`.

## Timing

- `write_new` in cycle t, FSM in IDLE and FIFO empty → `mem_req_valid` high in cycle t+2.
- `read_sync` in cycle t, FSM in IDLE and FIFO empty → read request valid in cycle t+2.
- `mem_rsp_valid` in cycle r → `MISO_data` updated in cycle r+1, `busy` low in r+1 if nothing else is queued.
- Back-to-back writes: one request per cycle while `mem_req_ready`=1.
- System requirement (not enforced by the block): the read must complete before the SPI client's next word boundary, i.e. within `MESSAGE_BIT_WIDTH` SCK periods minus synchronizer latency.
- Simultaneous `write_new` and `read_sync` in one cycle: both are captured, and the write is issued before the read.

## Test plan

- Single write: `code`=3, address 0x0010, data 0xDEADBEEF, `mem_req_ready`=1 → one request in cycle t+2 with `write`=1 and these values; `busy` low by t+4.
- Back-pressure and full FIFO: `mem_req_ready`=0, five writes with `FIFO_DEPTH`=4 → fifth write dropped, `overflow`=1. Release ready → four requests in push order on consecutive cycles.
- Read: `read_sync` with address 0x0042, ready=1, `mem_rsp_valid` with data 0x12345678 three cycles later → `MISO_data`=0x12345678 one cycle after the response.
- Write-then-read ordering: two writes then `read_sync` → read request appears only after both write handshakes.
- Code-0 write plus read overrun: code-0 write → no request, `overflow` stays 0. Two `read_sync` pulses without a response → `read_overrun`=1 and the first address is used.
- Reset in READ_WAIT → outputs return to their reset values. A later `mem_rsp_valid` leaves `MISO_data`=0.
